// File: rtl/stage_ex_mult_if.sv
// rtl/stage_ex_mult_if.sv - issue-side and CDB-side handshake bundle for the multiply unit
interface stage_ex_mult_if #(
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_opa;
  logic [31:0]      in_opb;
  logic [1:0]       in_func;
  logic [TAG_W-1:0] in_dest_tag;
  logic [ROB_W-1:0] in_rob_idx;
  logic             out_valid;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_dest_tag;
  logic [ROB_W-1:0] out_rob_idx;
  logic             cdb_grant;

  modport master (
    output in_valid, in_opa, in_opb, in_func, in_dest_tag, in_rob_idx, cdb_grant,
    input  in_ready, out_valid, out_result, out_dest_tag, out_rob_idx
  );

  modport slave (
    input  in_valid, in_opa, in_opb, in_func, in_dest_tag, in_rob_idx, cdb_grant,
    output in_ready, out_valid, out_result, out_dest_tag, out_rob_idx
  );
endinterface

// File: rtl/stage_ex_mult.sv
// rtl/stage_ex_mult.sv - lock-step pipelined RV32M multiply unit with CDB back-pressure and squash
module stage_ex_mult #(
  parameter int NUM_STAGES = 4,
  parameter int TAG_W      = 6,
  parameter int ROB_W      = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash,
  stage_ex_mult_if.slave      bus,
  output logic [3:0]          busy_count
);
  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] valid_d;
  logic [TAG_W-1:0]      tag_q [NUM_STAGES];
  logic [ROB_W-1:0]      rob_q [NUM_STAGES];
  logic [31:0]           res_q [1:NUM_STAGES-1];
  logic [32:0]           a_q;
  logic [32:0]           b_q;
  logic                  hi_q;
  logic                  advance;
  logic                  sign_a;
  logic                  sign_b;
  logic [63:0]           prod;
  logic [31:0]           mul_res;
  logic [3:0]            busy_d;

  assign advance      = !valid_q[NUM_STAGES-1] || bus.cdb_grant;
  assign bus.in_ready = advance;

  assign sign_a = (bus.in_func == 2'd1) || (bus.in_func == 2'd2);
  assign sign_b = (bus.in_func == 2'd1);

  // Stage 0 holds the 33-bit extended operands; the multiply sits between stage 0 and 1.
  assign prod    = {{31{a_q[32]}}, a_q} * {{31{b_q[32]}}, b_q};
  assign mul_res = hi_q ? prod[63:32] : prod[31:0];

  always_comb begin
    valid_d = valid_q;
    if (squash)
      valid_d = '0;
    else if (advance)
      valid_d = {valid_q[NUM_STAGES-2:0], bus.in_valid};
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      busy_d = busy_d + {3'b000, valid_d[i]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      busy_count <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        tag_q[i] <= '0;
        rob_q[i] <= '0;
      end
      for (int i = 1; i < NUM_STAGES; i++)
        res_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      busy_count <= busy_d;
      if (advance && !squash) begin
        a_q      <= {sign_a & bus.in_opa[31], bus.in_opa};
        b_q      <= {sign_b & bus.in_opb[31], bus.in_opb};
        hi_q     <= (bus.in_func != 2'd0);
        tag_q[0] <= bus.in_dest_tag;
        rob_q[0] <= bus.in_rob_idx;
        res_q[1] <= mul_res;
        for (int i = 1; i < NUM_STAGES; i++) begin
          tag_q[i] <= tag_q[i-1];
          rob_q[i] <= rob_q[i-1];
        end
        for (int i = 2; i < NUM_STAGES; i++)
          res_q[i] <= res_q[i-1];
      end
    end
  end

  assign bus.out_valid    = valid_q[NUM_STAGES-1];
  assign bus.out_result   = res_q[NUM_STAGES-1];
  assign bus.out_dest_tag = tag_q[NUM_STAGES-1];
  assign bus.out_rob_idx  = rob_q[NUM_STAGES-1];
endmodule

// File: tb/tb_stage_ex_mult.sv
// tb/tb_stage_ex_mult.sv - scoreboard bench for the pipelined multiply unit
module tb_stage_ex_mult;
  logic       clock;
  logic       reset;
  logic       squash;
  logic [3:0] busy_count;

  stage_ex_mult_if #(.TAG_W(6), .ROB_W(5)) bus ();

  stage_ex_mult #(.NUM_STAGES(4), .TAG_W(6), .ROB_W(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .squash     (squash),
    .bus        (bus),
    .busy_count (busy_count)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [4:0]  rob;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   grant_rand = 0;

  initial clock = 0;
  always #5 clock = ~clock;

  // Reference: sign/zero-extend each operand to 64 bits per function, wrap-multiply.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    longint sa, sb, p;
    sa = (f == 2'd1 || f == 2'd2) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (f == 2'd1) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = sa * sb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: a result is consumed when out_valid && cdb_grant at an edge with no reset/squash.
  always @(negedge clock) begin
    if (bus.out_valid && bus.cdb_grant && !reset && !squash) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: result=%h tag=%0d rob=%0d with empty scoreboard",
                 bus.out_result, bus.out_dest_tag, bus.out_rob_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_checks += 2;
        if (bus.out_result !== e.res) begin
          n_fail++;
          $display("FAIL out_result: got %h expected %h", bus.out_result, e.res);
        end
        if (bus.out_dest_tag !== e.tag) begin
          n_fail++;
          $display("FAIL out_dest_tag: got %0d expected %0d", bus.out_dest_tag, e.tag);
        end
        if (bus.out_rob_idx !== e.rob) begin
          n_fail++;
          $display("FAIL out_rob_idx: got %0d expected %0d", bus.out_rob_idx, e.rob);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #2;
      if (grant_rand) bus.cdb_grant = 1'($urandom_range(0, 1));
    end
  end

  // Present an op from just after an edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                      input logic [5:0] tag, input logic [4:0] rob, input logic [31:0] exp_res);
    bit acc;
    acc = 0;
    bus.in_valid = 1; bus.in_opa = a; bus.in_opb = b; bus.in_func = f;
    bus.in_dest_tag = tag; bus.in_rob_idx = rob;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      acc = bus.in_ready && !squash && !reset;
      if (acc) q.push_back('{res: exp_res, tag: tag, rob: rob});
      @(posedge clock);
      #1;
      if (acc) break;
    end
    bus.in_valid = 0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready never seen, tag=%0d", tag);
    end
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    bus.cdb_grant = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (q.size() == 0 && busy_count == 0) begin ok = 1; break; end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1; squash = 0; bus.in_valid = 0; bus.cdb_grant = 0;
    bus.in_opa = 0; bus.in_opb = 0; bus.in_func = 0; bus.in_dest_tag = 0; bus.in_rob_idx = 0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    if (busy_count !== 4'd0) begin n_fail++; $display("FAIL reset_busy: got %0d expected 0", busy_count); end
    if ({bus.out_result, bus.out_dest_tag, bus.out_rob_idx} !== 43'd0) begin
      n_fail++; $display("FAIL reset_out_fields: got %h/%0d/%0d expected 0/0/0", bus.out_result, bus.out_dest_tag, bus.out_rob_idx);
    end
    @(posedge clock);
    #1 reset = 0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic_latency;
    bit ok;
    bus.cdb_grant = 1;
    send(32'd7, 32'd6, 2'd0, 6'd5, 5'd3, 32'd42);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== (k == 3)) begin
        n_fail++; $display("FAIL basic_latency: cycle %0d after accept out_valid=%b expected %b", k, bus.out_valid, (k == 3));
      end
    end
    @(posedge clock);
    #1;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  task automatic test_signs;
    bit ok;
    bus.cdb_grant = 1;
    send(32'hFFFFFFFF, 32'h2, 2'd1, 6'd10, 5'd1, 32'hFFFFFFFF);
    send(32'hFFFFFFFF, 32'h2, 2'd2, 6'd11, 5'd2, 32'hFFFFFFFF);
    send(32'hFFFFFFFF, 32'h2, 2'd3, 6'd12, 5'd3, 32'h00000001);
    send(32'hFFFFFFFF, 32'h2, 2'd0, 6'd13, 5'd4, 32'hFFFFFFFE);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL signs_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  task automatic test_overflow;
    bit ok;
    bus.cdb_grant = 1;
    send(32'h80000000, 32'h80000000, 2'd1, 6'd20, 5'd5, 32'h40000000);
    send(32'h80000000, 32'h80000000, 2'd0, 6'd21, 5'd6, 32'h00000000);
    send(32'h80000000, 32'h80000000, 2'd3, 6'd22, 5'd7, 32'h40000000);
    send(32'h80000000, 32'h80000000, 2'd2, 6'd23, 5'd8, 32'hC0000000);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overflow_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic [31:0] held_res;
    logic [5:0]  held_tag;
    bus.cdb_grant = 0;
    for (int i = 0; i < 4; i++)
      send(32'd100 + i, 32'd3, 2'd0, 6'd30 + 6'(i), 5'd10 + 5'(i), 32'd300 + 32'(3 * i));
    @(negedge clock);
    n_checks += 3;
    if (busy_count !== 4'd4) begin n_fail++; $display("FAIL bp_full_busy: got %0d expected 4", busy_count); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", bus.in_ready); end
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid: got %b expected 1", bus.out_valid); end
    held_res = bus.out_result;
    held_tag = bus.out_dest_tag;
    @(posedge clock);
    #1;
    bus.in_valid = 1; bus.in_opa = 32'd104; bus.in_opb = 32'd3; bus.in_func = 2'd0;
    bus.in_dest_tag = 6'd34; bus.in_rob_idx = 5'd14;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks += 3;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: got %b expected 0", bus.in_ready); end
      if (bus.out_result !== held_res) begin n_fail++; $display("FAIL bp_stable_result: got %h expected %h", bus.out_result, held_res); end
      if (bus.out_dest_tag !== held_tag || busy_count !== 4'd4) begin
        n_fail++; $display("FAIL bp_stable_tag_busy: got %0d/%0d expected %0d/4", bus.out_dest_tag, busy_count, held_tag);
      end
      @(posedge clock);
      #1;
    end
    bus.cdb_grant = 1;
    @(negedge clock);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_grant_ready: got %b expected 1", bus.in_ready);
    end else begin
      q.push_back('{res: 32'd312, tag: 6'd34, rob: 5'd14});
    end
    @(posedge clock);
    #1;
    bus.cdb_grant = 0;
    bus.in_valid = 0;
    @(negedge clock);
    n_checks += 2;
    if (busy_count !== 4'd4) begin n_fail++; $display("FAIL bp_swap_busy: got %0d expected 4", busy_count); end
    if (bus.out_dest_tag !== 6'd31) begin n_fail++; $display("FAIL bp_order: head tag %0d expected 31", bus.out_dest_tag); end
    @(posedge clock);
    #1;
    bus.cdb_grant = 1;
    send(32'd105, 32'd3, 2'd0, 6'd35, 5'd15, 32'd315);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  task automatic test_squash;
    bus.cdb_grant = 1;
    send(32'd2, 32'd2, 2'd0, 6'd40, 5'd20, 32'd4);
    send(32'd2, 32'd3, 2'd0, 6'd41, 5'd21, 32'd6);
    send(32'd2, 32'd4, 2'd0, 6'd42, 5'd22, 32'd8);
    @(posedge clock);
    #1;
    squash = 1;
    bus.in_valid = 1; bus.in_opa = 32'd5; bus.in_opb = 32'd5; bus.in_func = 2'd0;
    bus.in_dest_tag = 6'd43; bus.in_rob_idx = 5'd23;
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b1 || busy_count !== 4'd3) begin
      n_fail++; $display("FAIL squash_setup: out_valid=%b busy=%0d expected 1/3", bus.out_valid, busy_count);
    end
    @(posedge clock);
    #1;
    squash = 0;
    bus.in_valid = 0;
    q.delete();
    @(negedge clock);
    n_checks += 3;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL squash_out_valid: got %b expected 0", bus.out_valid); end
    if (busy_count !== 4'd0) begin n_fail++; $display("FAIL squash_busy: got %0d expected 0", busy_count); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL squash_ready: got %b expected 1", bus.in_ready); end
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid;
    bit ok;
    bus.cdb_grant = 0;
    for (int i = 0; i < 4; i++)
      send(32'd9, 32'd9 + i, 2'd0, 6'd50 + 6'(i), 5'd24 + 5'(i), 32'd0);
    reset = 1;
    @(posedge clock);
    #1;
    q.delete();
    @(negedge clock);
    n_checks += 2;
    if (bus.out_valid !== 1'b0 || busy_count !== 4'd0) begin
      n_fail++; $display("FAIL midreset_valid_busy: got %b/%0d expected 0/0", bus.out_valid, busy_count);
    end
    if ({bus.out_result, bus.out_dest_tag, bus.out_rob_idx} !== 43'd0) begin
      n_fail++; $display("FAIL midreset_fields: got %h/%0d/%0d expected 0/0/0", bus.out_result, bus.out_dest_tag, bus.out_rob_idx);
    end
    @(posedge clock);
    #1;
    reset = 0;
    bus.cdb_grant = 1;
    send(32'd3, 32'd3, 2'd0, 6'd60, 5'd30, 32'd9);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (bus.out_valid !== (k == 3)) begin
        n_fail++; $display("FAIL midreset_latency: cycle %0d out_valid=%b expected %b", k, bus.out_valid, (k == 3));
      end
    end
    @(posedge clock);
    #1;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midreset_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  task automatic test_random;
    bit ok;
    logic [31:0] a, b;
    logic [1:0]  f;
    grant_rand = 1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      if (i % 7 == 0) b = 32'hFFFFFFFF;
      f = 2'(i % 4);
      send(a, b, f, 6'(i), 5'(i), model(a, b, f));
    end
    grant_rand = 0;
    @(posedge clock);
    #1;
    drain(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL random_drain: queue=%0d busy=%0d expected 0/0", q.size(), busy_count); end
  endtask

  initial begin
    test_reset;
    test_basic_latency;
    test_signs;
    test_back_to_back;
    test_overflow;
    test_squash;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
